multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS datapath, directly upstream of the ALU control decoder: sequences each instruction through fetch/decode/execute/memory/writeback and drives every datapath enable and mux select, including the 2-bit `aluop` consumed by ALU control. It supports R-type, lw, sw, beq, addi and j, plus a memory-ready handshake for variable-latency memory. Unsupported opcodes trap.

## Interface
- No parameters. Opcode, state and aluop encodings are constants in the shared package.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  6  opcode field from the instruction register.
- `mem_ready`  in  1  memory completed the current read/write this cycle.
- `aluop`  out  2  00 add, 01 sub, 10 decode from funct.
- `alusrca`  out  1  0 PC, 1 register A.
- `alusrcb`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `pcsrc`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `pcwrite`  out  1  unconditional PC write.
- `branch`  out  1  PC write qualified by ALU zero.
- `iord`  out  1  memory address: 0 PC, 1 ALUOut.
- `memread`, `memwrite`  out  1 each  memory strobes.
- `irwrite`  out  1  instruction register load.
- `regdst`  out  1  0 rt, 1 rd.
- `memtoreg`  out  1  0 ALUOut, 1 MDR.
- `regwrite`  out  1  register file write.
- `illegal_op`  out  1  trap indicator.
- `state`  out  4  current state, for debug.

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, ADDI_EX, ADDI_WB, JUMP, TRAP.
- Outputs not listed for a state are 0.
- RESET: all outputs 0; next state is FETCH unconditionally.
- FETCH: memread=1, alusrcb=01, aluop=00, irwrite=pcwrite=mem_ready. Holds until mem_ready, then goes to DECODE.
- DECODE: alusrcb=11, aluop=00 to precompute the branch target.
- DECODE transitions by `op`:
  - 100011 or 101011 → MEMADR
  - 000000 → RTYPE_EX
  - 000100 → BEQ_EX
  - 001000 → ADDI_EX
  - 000010 → JUMP
  - any other value → TRAP
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if op=lw, MEMWR if op=sw.
- MEMRD: iord=1, memread=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1. Holds until mem_ready, then goes to FETCH.
- RTYPE_EX: alusrca=1, alusrcb=00, aluop=10 → RTYPE_WB.
- RTYPE_WB: regdst=1, regwrite=1 → FETCH.
- BEQ_EX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 → FETCH.
- ADDI_EX: alusrca=1, alusrcb=10, aluop=00 → ADDI_WB.
- ADDI_WB: regwrite=1 → FETCH.
- JUMP: pcsrc=10, pcwrite=1 → FETCH.
- TRAP: illegal_op=1, no writes. Held until reset.

## Timing
- Outputs are combinational from `state`, except FETCH, where `irwrite` and `pcwrite` also depend on `mem_ready`. There is no extra output register.
- Reset: `state` goes to RESET immediately while rst_n=0, independent of clk. All outputs read 0 during reset and for the first cycle after release. FETCH begins on the second rising edge after release.
- Cycles from FETCH entry back to the next FETCH, with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes stay asserted and the address is held throughout the wait.
- `mem_ready` is ignored in all other states. If it is high in DECODE, nothing happens.
- `op` is sampled only in DECODE and MEMADR. It must be stable from DECODE until the instruction completes; IR is not reloaded before then.
- Reset asserted mid-instruction: the instruction is abandoned and no further strobes are issued.
- `state` encoding: RESET=0, FETCH=1, … TRAP=13, in the order listed under Operation.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - aluop constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - the 4-bit state constants
- ALU control imports the same aluop constants.
- Single module, no sub-module. It has one state register block with asynchronous reset, one next-state block and one output-decode block.

## Test plan
- Reset then lw, mem_ready=1 always: state sequence 0,1,2,3,4,5,1.
  - Cycle in FETCH: irwrite=pcwrite=1.
  - Cycle in MEMWB: regwrite=1, memtoreg=1, regdst=0.
- R-type (op=000000): aluop=10 in RTYPE_EX. Next cycle regwrite=1, regdst=1. Then FETCH; 4 cycles total.
- sw with mem_ready held low 3 cycles in MEMWR: memwrite=1, iord=1 for 4 cycles, then FETCH. No regwrite at any point.
- beq: DECODE shows alusrcb=11. BEQ_EX shows aluop=01, branch=1, pcsrc=01, pcwrite=0.
- j then op=111111: JUMP asserts pcwrite=1, pcsrc=10. The next DECODE goes to TRAP; illegal_op=1 and all write enables stay 0 for 10+ cycles.
- rst_n dropped mid-MEMRD, between clock edges: state=0 and all outputs 0 immediately. After release, one RESET cycle, then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU op
// classes consumed by ALU control, and the main FSM state numbering.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMRD    = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWR    = 4'd6;
  localparam logic [3:0] S_RTYPE_EX = 4'd7;
  localparam logic [3:0] S_RTYPE_WB = 4'd8;
  localparam logic [3:0] S_BEQ_EX   = 4'd9;
  localparam logic [3:0] S_ADDI_EX  = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each
// instruction and drives every datapath enable, mux select and aluop.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic [1:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_next;
  // Set on the first edge after reset release so RESET lasts one full cycle.
  logic       started;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RESET;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:    state_next = started ? S_FETCH : S_RESET;
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPE_EX;
          OP_BEQ:       state_next = S_BEQ_EX;
          OP_ADDI:      state_next = S_ADDI_EX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_TRAP;
      end
      S_MEMRD:    if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWR:    if (mem_ready) state_next = S_FETCH;
      S_RTYPE_EX: state_next = S_RTYPE_WB;
      S_RTYPE_WB: state_next = S_FETCH;
      S_BEQ_EX:   state_next = S_FETCH;
      S_ADDI_EX:  state_next = S_ADDI_WB;
      S_ADDI_WB:  state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase
  end

  always_comb begin
    aluop      = ALUOP_ADD;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPE_EX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQ_EX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDI_WB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      S_TRAP:  illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class and
// checks state sequence and control outputs against hand-computed values.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic [1:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcwrite;
  logic       branch;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       illegal_op;
  logic [3:0] state;

  int unsigned total;
  int unsigned bad;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .aluop      (aluop),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [16:0] outs;
  assign outs = {aluop, alusrca, alusrcb, pcsrc, pcwrite, branch, iord, memread,
                 memwrite, irwrite, regdst, memtoreg, regwrite, illegal_op};

  logic [5:0] writes;
  assign writes = {pcwrite, branch, memwrite, regwrite, irwrite, memread};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    op = 6'b100011;
    mem_ready = 1'b1;

    #22;
    check("rst_state", state, 0);
    check("rst_outs", outs, 0);
    rst_n = 1'b1;

    // lw: 0,1,2,3,4,5,1
    tick();
    check("lw_s0", state, 0);
    check("lw_s0_outs", outs, 0);
    tick();
    check("lw_s1", state, 1);
    check("fetch_irwrite", irwrite, 1);
    check("fetch_pcwrite", pcwrite, 1);
    check("fetch_memread", memread, 1);
    check("fetch_alusrcb", alusrcb, 2'b01);
    tick();
    check("lw_s2", state, 2);
    tick();
    check("lw_s3", state, 3);
    check("memadr_srca", alusrca, 1);
    check("memadr_srcb", alusrcb, 2'b10);
    tick();
    check("lw_s4", state, 4);
    check("memrd_iord_rd", {iord, memread}, 2'b11);
    tick();
    check("lw_s5", state, 5);
    check("memwb_rw_m2r_rd", {regwrite, memtoreg, regdst}, 3'b110);
    tick();
    check("lw_s1_end", state, 1);

    // R-type, 4 cycles FETCH to FETCH
    op = 6'b000000;
    tick();
    check("r_dec", state, 2);
    tick();
    check("r_ex", state, 7);
    check("r_ex_aluop", aluop, 2'b10);
    check("r_ex_srca", alusrca, 1);
    tick();
    check("r_wb", state, 8);
    check("r_wb_rw_rd", {regwrite, regdst}, 2'b11);
    tick();
    check("r_fetch", state, 1);

    // fetch wait: mem_ready low holds FETCH and gates irwrite/pcwrite
    mem_ready = 1'b0;
    #1;
    check("fw_ir_pc", {irwrite, pcwrite}, 2'b00);
    check("fw_memread", memread, 1);
    tick();
    check("fw_hold", state, 1);
    mem_ready = 1'b1;
    #1;
    check("fw_ir_pc_go", {irwrite, pcwrite}, 2'b11);

    // sw with 3 wait cycles in MEMWR
    op = 6'b101011;
    tick();
    check("sw_dec", state, 2);
    check("sw_dec_rw", regwrite, 0);
    tick();
    check("sw_adr", state, 3);
    check("sw_adr_rw", regwrite, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check("sw_wr_state", state, 6);
      check("sw_wr_mw_iord", {memwrite, iord}, 2'b11);
      check("sw_wr_rw", regwrite, 0);
      tick();
    end
    check("sw_fetch", state, 1);

    // beq; mem_ready high in DECODE must be ignored
    op = 6'b000100;
    mem_ready = 1'b1;
    tick();
    check("beq_dec", state, 2);
    check("dec_srcb", alusrcb, 2'b11);
    check("dec_aluop", aluop, 2'b00);
    check("dec_writes", writes, 0);
    tick();
    check("beq_ex", state, 9);
    check("beq_aluop", aluop, 2'b01);
    check("beq_branch", branch, 1);
    check("beq_pcsrc", pcsrc, 2'b01);
    check("beq_pcwrite", pcwrite, 0);
    tick();
    check("beq_fetch", state, 1);

    // addi
    op = 6'b001000;
    tick();
    tick();
    check("addi_ex", state, 10);
    check("addi_ex_src", {alusrca, alusrcb, aluop}, 5'b11000);
    tick();
    check("addi_wb", state, 11);
    check("addi_wb_rw_rd", {regwrite, regdst}, 2'b10);
    tick();
    check("addi_fetch", state, 1);

    // j, then illegal opcode
    op = 6'b000010;
    tick();
    tick();
    check("j_state", state, 12);
    check("j_pcwrite", pcwrite, 1);
    check("j_pcsrc", pcsrc, 2'b10);
    tick();
    check("j_fetch", state, 1);
    op = 6'b111111;
    tick();
    check("bad_dec", state, 2);
    tick();
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0];
      #1;
      check("trap_state", state, 13);
      check("trap_illegal", illegal_op, 1);
      check("trap_writes", writes, 0);
      tick();
    end

    // recover via reset, then abort lw mid-MEMRD
    rst_n = 1'b0;
    #2;
    check("trap_rst", state, 0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    op = 6'b100011;
    tick();
    check("rec_reset", state, 0);
    tick();
    check("rec_fetch", state, 1);
    tick();
    tick();
    tick();
    check("abort_memrd", state, 4);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_state", state, 0);
    check("abort_outs", outs, 0);
    tick();
    check("abort_held", outs, 0);
    #3;
    rst_n = 1'b1;
    tick();
    check("abort_reset_cyc", state, 0);
    check("abort_reset_outs", outs, 0);
    tick();
    check("abort_fetch", state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
